// File: rtl/key_conditioner.sv
// Push-button front end: per-key synchroniser and debouncer, press pulses,
// auto-repeat on the advance key, and a registered run/pause flag.
module key_conditioner #(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_adv,
  input  logic       key_start,
  input  logic       key_pause,
  output logic       adv_pulse,
  output logic       start_pulse,
  output logic       pause_pulse,
  output logic       paused,
  output logic [2:0] key_level
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  // Terminal counts are "one before the target": the flip/pulse happens on
  // the edge where the counter would otherwise reach the parameter value.
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DELAY, REPEAT} rpt_state_t;

  logic [2:0] raw_norm;
  logic [2:0] flip;
  logic [2:0] rise;
  logic       adv_fall;

  assign raw_norm = {key_pause, key_start, key_adv} ^ {3{ACTIVE_LOW}};

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    logic            sync1_reg;
    logic            sync2_reg;
    logic            level_reg;
    logic [DB_W-1:0] cnt_reg;

    assign flip[gi]      = (sync2_reg != level_reg) && (cnt_reg == DB_LAST);
    assign key_level[gi] = level_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        level_reg <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        sync1_reg <= raw_norm[gi];
        sync2_reg <= sync1_reg;
        if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (flip[gi]) begin
          level_reg <= ~level_reg;
          cnt_reg   <= '0;
        end else if (cnt_reg != '1) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rise     = flip & ~key_level;
  assign adv_fall = flip[0] & key_level[0];

  rpt_state_t       state_reg, state_next;
  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic             repeat_fire;

  always_comb begin
    state_next   = state_reg;
    rpt_cnt_next = rpt_cnt_reg;
    repeat_fire  = 1'b0;
    if (REPEAT_DELAY == 0) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise[0]) begin
            state_next   = WAIT_DELAY;
            rpt_cnt_next = '0;
          end
        end
        WAIT_DELAY: begin
          if (rpt_cnt_reg == DELAY_LAST) begin
            repeat_fire  = 1'b1;
            state_next   = REPEAT;
            rpt_cnt_next = '0;
          end else if (rpt_cnt_reg != '1) begin
            rpt_cnt_next = rpt_cnt_reg + 1'b1;
          end
        end
        REPEAT: begin
          if (rpt_cnt_reg == PERIOD_LAST) begin
            repeat_fire  = 1'b1;
            rpt_cnt_next = '0;
          end else if (rpt_cnt_reg != '1) begin
            rpt_cnt_next = rpt_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end
      endcase
      // Release wins over a repeat that falls due on the same edge.
      if (adv_fall) begin
        state_next   = IDLE;
        rpt_cnt_next = '0;
        repeat_fire  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      rpt_cnt_reg <= '0;
      adv_pulse   <= 1'b0;
      start_pulse <= 1'b0;
      pause_pulse <= 1'b0;
      paused      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rpt_cnt_reg <= rpt_cnt_next;
      adv_pulse   <= rise[0] | repeat_fire;
      start_pulse <= rise[1];
      pause_pulse <= rise[2];
      // Start has priority so a simultaneous start+pause resumes.
      if (start_pulse)
        paused <= 1'b0;
      else if (pause_pulse)
        paused <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: expected pulse edges are queued
// when keys are driven and matched against the DUT pulses as they appear.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_adv, key_start, key_pause;
  logic       adv_pulse, start_pulse, pause_pulse, paused;
  logic [2:0] key_level;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int exp_adv[$];
  int exp_start[$];
  int exp_pause[$];

  key_conditioner #(
    .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk), .reset(reset),
    .key_adv(key_adv), .key_start(key_start), .key_pause(key_pause),
    .adv_pulse(adv_pulse), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
    .paused(paused), .key_level(key_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // One clock, then match every pulse output against its expectation queue.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (adv_pulse) begin
      checks++;
      if (exp_adv.size() == 0 || exp_adv[0] != edge_n) begin
        errors++;
        $display("FAIL adv_pulse: pulse at edge %0d, expected edge %0d", edge_n,
                 (exp_adv.size() != 0) ? exp_adv[0] : -1);
      end else begin
        void'(exp_adv.pop_front());
        $display("adv_pulse   at edge %0d as expected", edge_n);
      end
    end else if (exp_adv.size() != 0 && exp_adv[0] == edge_n) begin
      checks++; errors++;
      $display("FAIL adv_pulse: got 0 at edge %0d, required 1", edge_n);
      void'(exp_adv.pop_front());
    end
    if (start_pulse) begin
      checks++;
      if (exp_start.size() == 0 || exp_start[0] != edge_n) begin
        errors++;
        $display("FAIL start_pulse: pulse at edge %0d, expected edge %0d", edge_n,
                 (exp_start.size() != 0) ? exp_start[0] : -1);
      end else begin
        void'(exp_start.pop_front());
        $display("start_pulse at edge %0d as expected", edge_n);
      end
    end else if (exp_start.size() != 0 && exp_start[0] == edge_n) begin
      checks++; errors++;
      $display("FAIL start_pulse: got 0 at edge %0d, required 1", edge_n);
      void'(exp_start.pop_front());
    end
    if (pause_pulse) begin
      checks++;
      if (exp_pause.size() == 0 || exp_pause[0] != edge_n) begin
        errors++;
        $display("FAIL pause_pulse: pulse at edge %0d, expected edge %0d", edge_n,
                 (exp_pause.size() != 0) ? exp_pause[0] : -1);
      end else begin
        void'(exp_pause.pop_front());
        $display("pause_pulse at edge %0d as expected", edge_n);
      end
    end else if (exp_pause.size() != 0 && exp_pause[0] == edge_n) begin
      checks++; errors++;
      $display("FAIL pause_pulse: got 0 at edge %0d, required 1", edge_n);
      void'(exp_pause.pop_front());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({adv_pulse, start_pulse, pause_pulse, paused, key_level} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {adv_pulse, start_pulse, pause_pulse, paused, key_level});
    end
    reset = 1'b0;
    ticks(10);
  endtask

  task automatic test_pause_then_start();
    key_pause = 1'b0;
    exp_pause.push_back(edge_n + 6);
    for (int i = 0; i < 20 && !pause_pulse; i++) tick();
    checks++;
    if (paused !== 1'b0) begin
      errors++; $display("FAIL paused_before_pause: got %b, required 0", paused);
    end
    key_pause = 1'b1;
    tick();
    checks++;
    if (paused !== 1'b1) begin
      errors++; $display("FAIL paused_after_pause: got %b, required 1", paused);
    end
    ticks(10);
    key_start = 1'b0;
    exp_start.push_back(edge_n + 6);
    for (int i = 0; i < 20 && !start_pulse; i++) tick();
    checks++;
    if (paused !== 1'b1) begin
      errors++; $display("FAIL paused_before_start: got %b, required 1", paused);
    end
    key_start = 1'b1;
    tick();
    checks++;
    if (paused !== 1'b0) begin
      errors++; $display("FAIL paused_after_start: got %b, required 0", paused);
    end
    ticks(10);
  endtask

  task automatic test_glitch_start();
    for (int g = 0; g < 4; g++) begin
      key_start = g[0];
      ticks(2);
    end
    key_start = 1'b0;
    exp_start.push_back(edge_n + 6);
    ticks(10);
    key_start = 1'b1;
    ticks(10);
  endtask

  task automatic test_simultaneous();
    key_pause = 1'b0;
    exp_pause.push_back(edge_n + 6);
    ticks(8);
    key_pause = 1'b1;
    ticks(10);
    checks++;
    if (paused !== 1'b1) begin
      errors++; $display("FAIL paused_setup: got %b, required 1", paused);
    end
    key_start = 1'b0;
    key_pause = 1'b0;
    exp_start.push_back(edge_n + 6);
    exp_pause.push_back(edge_n + 6);
    for (int i = 0; i < 20 && !start_pulse; i++) tick();
    checks++;
    if (key_level !== 3'b110) begin
      errors++; $display("FAIL key_level_both: got %b, required 110", key_level);
    end
    tick();
    checks++;
    if (paused !== 1'b0) begin
      errors++; $display("FAIL paused_both: got %b, required 0", paused);
    end
    key_start = 1'b1;
    key_pause = 1'b1;
    ticks(10);
  endtask

  // Release lands exactly on the P+40 repeat slot, which must be suppressed.
  task automatic test_auto_repeat();
    int p;
    p = edge_n + 6;
    key_adv = 1'b0;
    exp_adv.push_back(p);
    exp_adv.push_back(p + 16);
    exp_adv.push_back(p + 24);
    exp_adv.push_back(p + 32);
    ticks(40);
    key_adv = 1'b1;
    ticks(5);
    checks++;
    if (key_level[0] !== 1'b1) begin
      errors++; $display("FAIL adv_level_held: got %b, required 1", key_level[0]);
    end
    tick();
    checks++;
    if (key_level[0] !== 1'b0) begin
      errors++; $display("FAIL adv_level_released: got %b, required 0", key_level[0]);
    end
    ticks(20);
  endtask

  task automatic test_repress();
    int p;
    p = edge_n + 6;
    key_adv = 1'b0;
    exp_adv.push_back(p);
    exp_adv.push_back(p + 16);
    ticks(20);
    key_adv = 1'b1;
    ticks(15);
  endtask

  task automatic test_reset_mid_press();
    key_adv   = 1'b0;
    key_pause = 1'b0;
    exp_adv.push_back(edge_n + 6);
    exp_pause.push_back(edge_n + 6);
    ticks(8);
    key_pause = 1'b1;
    reset     = 1'b1;
    #1;
    checks++;
    if ({adv_pulse, start_pulse, pause_pulse, paused, key_level} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_press: got %b, required 0000000",
               {adv_pulse, start_pulse, pause_pulse, paused, key_level});
    end
    ticks(3);
    reset = 1'b0;
    exp_adv.push_back(edge_n + 6);
    ticks(14);
    key_adv = 1'b1;
    ticks(12);
  endtask

  initial begin
    reset     = 1'b1;
    key_adv   = 1'b1;
    key_start = 1'b1;
    key_pause = 1'b1;
    ticks(3);
    test_reset();
    test_pause_then_start();
    test_glitch_start();
    test_simultaneous();
    test_auto_repeat();
    test_repress();
    test_reset_mid_press();
    checks++;
    if (exp_adv.size() + exp_start.size() + exp_pause.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: got %0d outstanding, required 0",
               exp_adv.size() + exp_start.size() + exp_pause.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
